// File: rtl/l2_req_arbiter_pkg.sv
// Shared definitions for the L2 request arbiter: state encoding and parameter defaults.
// Kept alongside l2_cache.h so the C model and RTL agree on the encoding.
package l2_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GNT_IC  = 2'd1,
    ARB_GNT_DC  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int WDT_CYCLES_DEF = 1024;

  // The starvation counter saturates instead of wrapping back to zero.
  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/l2_req_arbiter_wdt.sv
// Grant watchdog for the L2 arbiter (built only with L2_ARB_WDT_EN).
// Fires when a grant has been held WDT_CYCLES cycles without its complete pulse.
module l2_arb_wdt #(
  parameter int WDT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_entry,
  input  logic in_grant,
  input  logic complete,
  output logic timeout,
  output logic wdt_err
);

  localparam int CW = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WDT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // A complete arriving on the limit cycle wins, so the transfer ends cleanly.
  assign timeout = in_grant && (cnt == LIMIT) && !complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      wdt_err <= 1'b0;
    end else begin
      wdt_err <= timeout;
      if (grant_entry)
        cnt <= '0;
      else if (in_grant)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates the single L2 controller between the L1 icache and dcache.
// Optional grant watchdog and wdt_err port enabled by defining L2_ARB_WDT_EN.
module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_rw,
  input  logic              drq,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_rw,
  input  logic              l2_busy,
  input  logic              complete_ic,
  input  logic              complete_dc,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_cache_rw,
  output logic              gnt_ic,
  output logic              gnt_dc,
  output logic [3:0]        starve_cnt
`ifdef L2_ARB_WDT_EN
  ,
  output logic              wdt_err
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state;
  logic       pick_dc;
  logic       wdt_fire;

  assign pick_dc = drq && (!irq || (starve_cnt < STARVE_LIM));

`ifdef L2_ARB_WDT_EN
  logic grant_entry;
  logic in_grant;
  logic grant_done;

  assign grant_entry = (state == ARB_IDLE) && !l2_busy && (drq || irq);
  assign in_grant    = (state == ARB_GNT_IC) || (state == ARB_GNT_DC);
  assign grant_done  = (state == ARB_GNT_IC) ? complete_ic : complete_dc;

  l2_arb_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk        (clk),
    .rst        (rst),
    .grant_entry(grant_entry),
    .in_grant   (in_grant),
    .complete   (grant_done),
    .timeout    (wdt_fire),
    .wdt_err    (wdt_err)
  );
`else
  assign wdt_fire = 1'b0;
`endif

  // Address and rw are latched only on grant entry and held for the whole grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      l2_req      <= 1'b0;
      l2_addr     <= '0;
      l2_cache_rw <= 1'b0;
      gnt_ic      <= 1'b0;
      gnt_dc      <= 1'b0;
      starve_cnt  <= 4'd0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (!l2_busy) begin
            if (pick_dc) begin
              state       <= ARB_GNT_DC;
              gnt_dc      <= 1'b1;
              l2_req      <= 1'b1;
              l2_addr     <= dc_addr;
              l2_cache_rw <= dc_rw;
              starve_cnt  <= irq ? starve_inc(starve_cnt) : 4'd0;
            end else if (irq) begin
              state       <= ARB_GNT_IC;
              gnt_ic      <= 1'b1;
              l2_req      <= 1'b1;
              l2_addr     <= ic_addr;
              l2_cache_rw <= ic_rw;
              starve_cnt  <= 4'd0;
            end
          end
        end
        ARB_GNT_IC: begin
          if (complete_ic || wdt_fire) begin
            state  <= ARB_RELEASE;
            gnt_ic <= 1'b0;
            l2_req <= 1'b0;
          end
        end
        ARB_GNT_DC: begin
          if (complete_dc || wdt_fire) begin
            state  <= ARB_RELEASE;
            gnt_dc <= 1'b0;
            l2_req <= 1'b0;
          end
        end
        ARB_RELEASE: state <= ARB_IDLE;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed testbench for l2_req_arbiter: table of per-cycle vectors plus hand sequences.
// The watchdog sequence is included when L2_ARB_WDT_EN is defined.
module tb_l2_req_arbiter;

  localparam logic [31:0] IC_A = 32'h0040_0000;
  localparam logic [31:0] DC_A = 32'h0000_1A40;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq, ic_rw, drq, dc_rw, l2_busy, complete_ic, complete_dc;
  logic [31:0] ic_addr, dc_addr;
  logic        l2_req, l2_cache_rw, gnt_ic, gnt_dc;
  logic [31:0] l2_addr;
  logic [3:0]  starve_cnt;
`ifdef L2_ARB_WDT_EN
  logic        wdt_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_req_arbiter #(
    .ADDR_W    (32),
    .STARVE_MAX(4),
    .WDT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .ic_addr    (ic_addr),
    .ic_rw      (ic_rw),
    .drq        (drq),
    .dc_addr    (dc_addr),
    .dc_rw      (dc_rw),
    .l2_busy    (l2_busy),
    .complete_ic(complete_ic),
    .complete_dc(complete_dc),
    .l2_req     (l2_req),
    .l2_addr    (l2_addr),
    .l2_cache_rw(l2_cache_rw),
    .gnt_ic     (gnt_ic),
    .gnt_dc     (gnt_dc),
    .starve_cnt (starve_cnt)
`ifdef L2_ARB_WDT_EN
    ,
    .wdt_err    (wdt_err)
`endif
  );

  typedef struct {
    logic        irq, drq, busy, cic, cdc;
    logic        req, gic, gdc;
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  starve;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic i, d, b, ci, cd, r, gi, gd,
                              input logic [31:0] a, input logic w, input logic [3:0] s);
    vec_t v;
    v.irq = i; v.drq = d; v.busy = b; v.cic = ci; v.cdc = cd;
    v.req = r; v.gic = gi; v.gdc = gd; v.addr = a; v.rw = w; v.starve = s;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic i, d, b, ci, cd);
    irq = i; drq = d; l2_busy = b; complete_ic = ci; complete_dc = cd;
    @(posedge clk);
    #1;
    complete_ic = 1'b0;
    complete_dc = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic r, gi, gd,
                          input logic [31:0] a, input logic w, input logic [3:0] s);
    checkOutput({tag, ".l2_req"}, 32'(l2_req), 32'(r));
    checkOutput({tag, ".gnt_ic"}, 32'(gnt_ic), 32'(gi));
    checkOutput({tag, ".gnt_dc"}, 32'(gnt_dc), 32'(gd));
    checkOutput({tag, ".l2_addr"}, l2_addr, a);
    checkOutput({tag, ".l2_cache_rw"}, 32'(l2_cache_rw), 32'(w));
    checkOutput({tag, ".starve_cnt"}, 32'(starve_cnt), 32'(s));
    checkOutput({tag, ".onehot"}, 32'(gnt_ic & gnt_dc), 32'd0);
  endtask

  initial begin
    // irq drq busy cic cdc | req gic gdc addr rw starve
    vecs[0]  = mk(1,1,0,0,0, 1,0,1, DC_A,1,1);
    vecs[1]  = mk(1,1,0,0,0, 1,0,1, DC_A,1,1);
    vecs[2]  = mk(1,1,0,0,1, 0,0,0, DC_A,1,1);
    vecs[3]  = mk(1,1,0,0,0, 0,0,0, DC_A,1,1);
    vecs[4]  = mk(1,1,0,0,0, 1,0,1, DC_A,1,2);
    vecs[5]  = mk(1,1,0,0,1, 0,0,0, DC_A,1,2);
    vecs[6]  = mk(1,1,0,0,0, 0,0,0, DC_A,1,2);
    vecs[7]  = mk(1,1,0,0,0, 1,0,1, DC_A,1,3);
    vecs[8]  = mk(1,1,0,0,1, 0,0,0, DC_A,1,3);
    vecs[9]  = mk(1,1,0,0,0, 0,0,0, DC_A,1,3);
    vecs[10] = mk(1,1,0,0,0, 1,0,1, DC_A,1,4);
    vecs[11] = mk(1,1,0,0,1, 0,0,0, DC_A,1,4);
    vecs[12] = mk(1,1,0,0,0, 0,0,0, DC_A,1,4);
    vecs[13] = mk(1,1,0,0,0, 1,1,0, IC_A,0,0);
    vecs[14] = mk(1,1,0,1,0, 0,0,0, IC_A,0,0);
    vecs[15] = mk(1,1,0,0,0, 0,0,0, IC_A,0,0);
    vecs[16] = mk(1,1,0,0,0, 1,0,1, DC_A,1,1);
    vecs[17] = mk(1,1,0,0,1, 0,0,0, DC_A,1,1);
    vecs[18] = mk(0,1,0,0,0, 0,0,0, DC_A,1,1);
    vecs[19] = mk(0,1,0,0,0, 1,0,1, DC_A,1,0);
    vecs[20] = mk(0,1,0,1,0, 1,0,1, DC_A,1,0);
    vecs[21] = mk(0,1,0,0,1, 0,0,0, DC_A,1,0);
    vecs[22] = mk(1,0,0,0,0, 0,0,0, DC_A,1,0);
    vecs[23] = mk(1,0,0,0,0, 1,1,0, IC_A,0,0);
    vecs[24] = mk(1,0,0,0,1, 1,1,0, IC_A,0,0);
    vecs[25] = mk(1,0,0,1,0, 0,0,0, IC_A,0,0);
    vecs[26] = mk(0,0,0,0,0, 0,0,0, IC_A,0,0);
    vecs[27] = mk(0,0,0,0,0, 0,0,0, IC_A,0,0);

    rst = 1'b0;
    irq = 1'b1; drq = 1'b1; l2_busy = 1'b0;
    complete_ic = 1'b0; complete_dc = 1'b0;
    ic_addr = IC_A; ic_rw = 1'b0;
    dc_addr = DC_A; dc_rw = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 0, 0, 0, 32'h0, 0, 4'd0);
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].irq, vecs[i].drq, vecs[i].busy, vecs[i].cic, vecs[i].cdc);
      checkAll($sformatf("vec%0d", i), vecs[i].req, vecs[i].gic, vecs[i].gdc,
               vecs[i].addr, vecs[i].rw, vecs[i].starve);
    end

    // Busy L2 blocks every new grant until it frees up.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput($sformatf("busy%0d.gnt_dc", i), 32'(gnt_dc), 32'd0);
    end
    applyStimulus(0, 1, 0, 0, 0);
    checkAll("busy_free", 1, 0, 1, DC_A, 1, 4'd0);

    // Asynchronous reset in the middle of a grant.
    rst = 1'b0;
    #1;
    checkAll("mid_reset", 0, 0, 0, 32'h0, 0, 4'd0);
    drq = 1'b0;
    #2;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkAll("post_reset_idle", 0, 0, 0, 32'h0, 0, 4'd0);

`ifdef L2_ARB_WDT_EN
    begin
      int k;
      checkOutput("wdt.idle_err", 32'(wdt_err), 32'd0);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("wdt.grant", 32'(gnt_dc), 32'd1);
      k = 0;
      while (k < 40 && !wdt_err) begin
        applyStimulus(0, 1, 0, 0, 0);
        k++;
      end
      checkOutput("wdt.fire_cycle", 32'(k), 32'd16);
      checkOutput("wdt.forced_release", 32'(gnt_dc), 32'd0);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("wdt.err_pulse", 32'(wdt_err), 32'd0);
      checkOutput("wdt.idle_gnt", 32'(gnt_dc), 32'd0);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("wdt.regrant", 32'(gnt_dc), 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
